spi_reg_master: RTL
===================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL provide parameters (name, default, meaning): SCK_HALF, 20, clk_in cycles per SCK half-period; CS_SETUP, 20, cycles from SS fall to first SCK rise; CMD_GAP, 164, idle cycles between command byte and data phase; CS_IDLE, 40, minimum SS-high cycles after a frame.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk_in  input  1  system clock, all logic on rising edge
- cnt_rstn  input  1  reset; asynchronous, active-low
- req  input  1  start transaction, sampled in IDLE only
- req_wr  input  1  1 = register write (cmd 0x03), 0 = register read (cmd 0x04)
- req_addr  input  8  register address
- req_wdata  input  16  write data
- busy  output  1  transaction in progress
- done  output  1  one-cycle completion pulse
- rdata  output  16  last read result
- spi_ss  output  1  chip select, active-low
- spi_sclk  output  1  SPI clock, CPOL=0/CPHA=0
- spi_mosi  output  1  master data out, MSB first
- spi_miso  input  1  slave data out, asynchronous to clk_in

Function
REQ-003 SHALL implement states IDLE, SETUP, CMD, GAP, DATA, HOLD, SSIDLE.
REQ-004 IDLE: on req=1 SHALL latch req_wr/req_addr/req_wdata, drive spi_ss=0, set busy=1 next cycle, go SETUP; req outside IDLE SHALL be ignored.
REQ-005 SETUP SHALL last CS_SETUP cycles with spi_sclk=0, spi_mosi = command MSB, then go CMD.
REQ-006 Each bit SHALL be SCK_HALF cycles low then SCK_HALF cycles high; spi_mosi SHALL change only at the start of the low half (at or after a SCK fall), never while spi_sclk=1.
REQ-007 CMD SHALL shift 8 bits MSB first: 0x03 when write, 0x04 when read; after 8th high half, spi_sclk=0, go GAP.
REQ-008 GAP SHALL hold spi_ss=0, spi_sclk=0 for CMD_GAP cycles, then go DATA.
REQ-009 Write DATA SHALL shift 24 bits MSB first: req_addr[7:0] then req_wdata[15:0].
REQ-010 Read DATA SHALL shift 24 bits: req_addr[7:0], then 16 zero bits on spi_mosi.
REQ-011 spi_miso SHALL pass a 2-flop synchronizer; read data SHALL be captured from the synchronized value on the last clk_in cycle before each SCK rise of data bits 9..24, shifted MSB first.
REQ-012 After 24th high half, DATA SHALL drive spi_sclk=0 and go HOLD; HOLD SHALL last SCK_HALF cycles, then drive spi_ss=1 and go SSIDLE.
REQ-013 rdata SHALL update with the 16 captured bits on the HOLD->SSIDLE transition for reads only; writes SHALL leave rdata unchanged.
REQ-014 SSIDLE SHALL hold spi_ss=1 for CS_IDLE cycles, then pulse done=1 for one cycle, deassert busy in that same cycle, return IDLE.
REQ-015 Total frame SHALL contain exactly 32 SCK rising edges; spi_sclk SHALL be 0 whenever spi_ss=1.
REQ-016 req held high continuously SHALL start a new transaction on the first IDLE cycle after done (back-to-back, no extra gap beyond CS_IDLE).
REQ-017 Internal counters SHALL be wide enough for parameter values up to 1023 without wrap.

Reset
REQ-018 On cnt_rstn=0, immediately: spi_ss=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, rdata=0x0000, state IDLE.
REQ-019 Reset asserted mid-transaction SHALL abandon it with no done pulse and no rdata update; first req after release SHALL start a clean frame.
REQ-020 Outputs SHALL hold reset values until the first accepted req after cnt_rstn rises.

Verification
REQ-021 Write req_addr=0x08, req_wdata=0x1388 -> MOSI bits 0x03 then 0x081388, 32 SCK rises, SS low-to-high span = CS_SETUP+16*SCK_HALF+CMD_GAP+48*SCK_HALF+SCK_HALF, done once, rdata stays 0x0000.
REQ-022 Read req_addr=0x07 with slave model returning 0xA5C3 on bits 9..24 -> MOSI 0x04, 0x07, 16 zeros; rdata=0xA5C3 at done.
REQ-023 req pulsed while busy=1 (addr 0x05) -> ignored, only original frame transmitted, one done.
REQ-024 cnt_rstn pulsed low during DATA bit 12 -> spi_ss=1, spi_sclk=0 same cycle, no done; subsequent write 0x02/0x0003 completes correctly.
REQ-025 req held high, two writes -> second SS fall exactly one cycle after done, SS high ≥ CS_IDLE between frames.
REQ-026 Loopback against the team's register-slave at 20 MHz sampling: write reg 3 = 0x1234, read reg 3 -> rdata=0x1234.

Source files
------------

// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI register master issuing 32-bit command/address/data frames
//
// Each frame is one command byte (0x03 write, 0x04 read), a gap, then 24 data
// bits: the address byte followed by 16 write-data bits. For reads, 16 zero
// bits are sent and the 16 read-data bits are sampled from MISO. SPI mode 0,
// MSB first.
//
// Ports:
//   clk_in     system clock, rising edge
//   cnt_rstn   asynchronous active-low reset
//   req        start a transaction (accepted in IDLE only)
//   req_wr     1 = register write, 0 = register read
//   req_addr   register address
//   req_wdata  write data
//   busy       transaction in progress
//   done       one-cycle completion pulse
//   rdata      result of the last completed read
//   spi_ss     chip select, active-low
//   spi_sclk   SPI clock (CPOL=0, CPHA=0)
//   spi_mosi   master data out
//   spi_miso   slave data in, asynchronous to clk_in
module spi_reg_master #(
    parameter int SCK_HALF = 20,
    parameter int CS_SETUP = 20,
    parameter int CMD_GAP  = 164,
    parameter int CS_IDLE  = 40
) (
    input  logic        clk_in,
    input  logic        cnt_rstn,
    input  logic        req,
    input  logic        req_wr,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        spi_ss,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {IDLE, SETUP, CMD, GAP, DATA, HOLD, SSIDLE} state_t;

    // Terminal counts; 10 bits covers parameter values up to 1023.
    localparam logic [9:0] HALF_LAST  = 10'(SCK_HALF - 1);
    localparam logic [9:0] SETUP_LAST = 10'(CS_SETUP - 1);
    localparam logic [9:0] GAP_LAST   = 10'(CMD_GAP - 1);
    localparam logic [9:0] IDLE_LAST  = 10'(CS_IDLE - 1);

    state_t      state;
    logic [9:0]  cnt;
    logic [4:0]  bit_cnt;     // frame bit index 0..31 (command bits are 0..7)
    logic [31:0] shreg;       // {cmd, addr, data}; bit 31 is the next bit out
    logic [15:0] rx;
    logic        is_wr;
    logic        miso_s1;
    logic        miso_s2;
    logic [7:0]  cmd_byte;

    assign cmd_byte = req_wr ? 8'h03 : 8'h04;

    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx       <= '0;
            is_wr    <= 1'b0;
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            spi_ss   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        is_wr    <= req_wr;
                        shreg    <= {cmd_byte, req_addr, req_wr ? req_wdata : 16'h0000};
                        spi_mosi <= cmd_byte[7];
                        spi_ss   <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= CMD;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                CMD, DATA: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            // Sample on the cycle before the rise of data bits 9..24.
                            if (state == DATA && bit_cnt[4])
                                rx <= {rx[14:0], miso_s2};
                        end else begin
                            // End of high half: SCK falls and MOSI advances together.
                            spi_sclk <= 1'b0;
                            shreg    <= {shreg[30:0], 1'b0};
                            spi_mosi <= shreg[30];
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (state == CMD && bit_cnt == 5'd7)
                                state <= GAP;
                            else if (bit_cnt == 5'd31)
                                state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        spi_ss   <= 1'b1;
                        spi_mosi <= 1'b0;
                        if (!is_wr)
                            rdata <= rx;
                        state    <= SSIDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                SSIDLE: begin
                    if (cnt == IDLE_LAST) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
